// File: rtl/rv_pkg.sv
// Shared RISC-V front-end definitions: opcodes, the canonical NOP and the BHT entry layout.
package rv_pkg;

  localparam int unsigned RV_XLEN = 32;

  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [31:0] NOP_INST   = 32'h00000013;

  localparam logic [1:0]  CTR_WEAK_NT = 2'b01;
  localparam logic [1:0]  CTR_WEAK_T  = 2'b10;

  // The tag is stored zero-extended to the full address width so one layout serves any table size.
  typedef struct packed {
    logic               valid;
    logic [RV_XLEN-1:0] tag;
    logic [RV_XLEN-1:0] target;
    logic [1:0]         ctr;
  } bht_entry_t;

endpackage

// File: rtl/bht_predictor.sv
// Direct-mapped branch history table with 2-bit saturating counters.
// The lookup is combinational; the update is registered, so a same-cycle lookup sees the old entry.
module bht_predictor
  import rv_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lookup_pc_i,
  output logic            lookup_taken_o,
  output logic [XLEN-1:0] lookup_target_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i
);

  localparam int unsigned IDX = $clog2(BHT_ENTRIES);

  bht_entry_t bht_q [BHT_ENTRIES];

  function automatic logic [IDX-1:0] idx_of(input logic [XLEN-1:0] pc);
    return pc[IDX+1:2];
  endfunction

  function automatic logic [XLEN-1:0] tag_of(input logic [XLEN-1:0] pc);
    return pc >> (IDX + 2);
  endfunction

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  logic [IDX-1:0] lk_idx, up_idx;
  bht_entry_t     lk_ent, up_ent;
  logic           up_hit;
  logic           unused_lsb;

  // Instructions are word aligned; the two low address bits never select anything.
  assign unused_lsb = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

  assign lk_idx          = idx_of(lookup_pc_i);
  assign lk_ent          = bht_q[lk_idx];
  assign lookup_taken_o  = lk_ent.valid && (lk_ent.tag == tag_of(lookup_pc_i)) && lk_ent.ctr[1];
  assign lookup_target_o = lk_ent.target;

  assign up_idx = idx_of(upd_pc_i);
  assign up_ent = bht_q[up_idx];
  assign up_hit = up_ent.valid && (up_ent.tag == tag_of(upd_pc_i));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
        bht_q[i].valid <= 1'b0;
        bht_q[i].ctr   <= CTR_WEAK_NT;
      end
    end else if (upd_valid_i) begin
      if (up_hit) begin
        bht_q[up_idx].ctr <= upd_taken_i ? ctr_inc(up_ent.ctr) : ctr_dec(up_ent.ctr);
        if (upd_taken_i) begin
          bht_q[up_idx].target <= upd_target_i;
        end
      end else if (upd_taken_i) begin
        bht_q[up_idx].valid  <= 1'b1;
        bht_q[up_idx].tag    <= tag_of(upd_pc_i);
        bht_q[up_idx].target <= upd_target_i;
        bht_q[up_idx].ctr    <= CTR_WEAK_T;
      end
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC register, BHT/JAL prediction, next-PC selection and the IF/ID register
// whose opcode/rs1/rs2 feed hazard detection.
module if_fetch_stage
  import rv_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     BHT_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write,
  input  logic            if_id_write,
  input  logic            ex_redirect_valid,
  input  logic [XLEN-1:0] ex_redirect_pc,
  input  logic            ex_br_valid,
  input  logic [XLEN-1:0] ex_br_pc,
  input  logic            ex_br_taken,
  input  logic [XLEN-1:0] ex_br_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_inst,
  output logic [6:0]      if_id_opcode,
  output logic [4:0]      if_id_rs1,
  output logic [4:0]      if_id_rs2,
  output logic            if_id_pred_taken,
  output logic [XLEN-1:0] if_id_pred_target
);

  function automatic logic [XLEN-1:0] jal_imm(input logic [31:0] inst);
    logic [20:0] imm;
    imm = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    return {{(XLEN-21){imm[20]}}, imm};
  endfunction

  logic [XLEN-1:0] pc_q, pc_d;
  logic            vld_q, vld_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [31:0]     id_inst_q, id_inst_d;
  logic            id_pt_q, id_pt_d;
  logic [XLEN-1:0] id_ptgt_q, id_ptgt_d;

  logic            bht_taken;
  logic [XLEN-1:0] bht_target;
  logic [6:0]      fetch_opc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  bht_predictor #(
    .XLEN        (XLEN),
    .BHT_ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk             (clk),
    .rst             (rst),
    .lookup_pc_i     (pc_q),
    .lookup_taken_o  (bht_taken),
    .lookup_target_o (bht_target),
    .upd_valid_i     (ex_br_valid),
    .upd_pc_i        (ex_br_pc),
    .upd_taken_i     (ex_br_taken),
    .upd_target_i    (ex_br_target)
  );

  assign imem_addr = pc_q;
  assign fetch_opc = imem_rdata[6:0];

  always_comb begin
    pred_taken  = 1'b0;
    pred_target = pc_q + XLEN'(4);
    if (fetch_opc == OPC_JAL) begin
      pred_taken  = 1'b1;
      pred_target = pc_q + jal_imm(imem_rdata);
    end else if ((fetch_opc == OPC_BRANCH) && bht_taken) begin
      pred_taken  = 1'b1;
      pred_target = bht_target;
    end
  end

  // A redirect overrides any stall, on both the PC and the IF/ID register.
  always_comb begin
    pc_d      = pred_target;
    vld_d     = 1'b1;
    id_pc_d   = pc_q;
    id_inst_d = imem_rdata;
    id_pt_d   = pred_taken;
    id_ptgt_d = pred_target;
    if (ex_redirect_valid) begin
      pc_d      = ex_redirect_pc;
      vld_d     = 1'b0;
      id_pc_d   = '0;
      id_inst_d = NOP_INST;
      id_pt_d   = 1'b0;
      id_ptgt_d = '0;
    end else begin
      if (!pc_write) begin
        pc_d = pc_q;
      end
      if (!if_id_write) begin
        vld_d     = vld_q;
        id_pc_d   = id_pc_q;
        id_inst_d = id_inst_q;
        id_pt_d   = id_pt_q;
        id_ptgt_d = id_ptgt_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      vld_q     <= 1'b0;
      id_pc_q   <= '0;
      id_inst_q <= NOP_INST;
      id_pt_q   <= 1'b0;
      id_ptgt_q <= '0;
    end else begin
      pc_q      <= pc_d;
      vld_q     <= vld_d;
      id_pc_q   <= id_pc_d;
      id_inst_q <= id_inst_d;
      id_pt_q   <= id_pt_d;
      id_ptgt_q <= id_ptgt_d;
    end
  end

  assign if_id_valid       = vld_q;
  assign if_id_pc          = id_pc_q;
  assign if_id_inst        = id_inst_q;
  assign if_id_opcode      = id_inst_q[6:0];
  assign if_id_rs1         = id_inst_q[19:15];
  assign if_id_rs2         = id_inst_q[24:20];
  assign if_id_pred_taken  = id_pt_q;
  assign if_id_pred_target = id_ptgt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: straight-line fetch, stalls, JAL, BHT training, redirect, reset.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write, if_id_write;
  logic        ex_redirect_valid;
  logic [31:0] ex_redirect_pc;
  logic        ex_br_valid, ex_br_taken;
  logic [31:0] ex_br_pc, ex_br_target;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_id_valid, if_id_pred_taken;
  logic [31:0] if_id_pc, if_id_inst, if_id_pred_target;
  logic [6:0]  if_id_opcode;
  logic [4:0]  if_id_rs1, if_id_rs2;

  logic [31:0] imem [256];
  int          n_chk = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem[imem_addr[9:2]];

  if_fetch_stage #(
    .XLEN        (32),
    .BHT_ENTRIES (16),
    .RESET_PC    (32'h0)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .pc_write          (pc_write),
    .if_id_write       (if_id_write),
    .ex_redirect_valid (ex_redirect_valid),
    .ex_redirect_pc    (ex_redirect_pc),
    .ex_br_valid       (ex_br_valid),
    .ex_br_pc          (ex_br_pc),
    .ex_br_taken       (ex_br_taken),
    .ex_br_target      (ex_br_target),
    .imem_addr         (imem_addr),
    .imem_rdata        (imem_rdata),
    .if_id_valid       (if_id_valid),
    .if_id_pc          (if_id_pc),
    .if_id_inst        (if_id_inst),
    .if_id_opcode      (if_id_opcode),
    .if_id_rs1         (if_id_rs1),
    .if_id_rs2         (if_id_rs2),
    .if_id_pred_taken  (if_id_pred_taken),
    .if_id_pred_target (if_id_pred_target)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] target);
    ex_redirect_valid = 1'b1;
    ex_redirect_pc    = target;
    step();
    ex_redirect_valid = 1'b0;
  endtask

  task automatic br_update(input logic taken, input int n);
    ex_br_valid  = 1'b1;
    ex_br_pc     = 32'h30;
    ex_br_taken  = taken;
    ex_br_target = 32'h80;
    for (int i = 0; i < n; i++) step();
    ex_br_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 32'h00000013;
    // R-type adds: {funct7, rs2, rs1, funct3, rd, opcode}
    imem[0]  = {7'd0, 5'd2,  5'd1,  3'd0, 5'd3, 7'b0110011};
    imem[1]  = {7'd0, 5'd7,  5'd5,  3'd0, 5'd4, 7'b0110011};
    imem[2]  = {7'd0, 5'd31, 5'd16, 3'd0, 5'd9, 7'b0110011};
    imem[3]  = {7'd0, 5'd10, 5'd11, 3'd0, 5'd1, 7'b0110011};
    imem[8]  = 32'h0400006F;  // jal x0, +0x40 at 0x20
    imem[12] = 32'h00000063;  // beq x0, x0 at 0x30

    rst = 1'b1; pc_write = 1'b1; if_id_write = 1'b1;
    ex_redirect_valid = 1'b0; ex_redirect_pc = '0;
    ex_br_valid = 1'b0; ex_br_pc = '0; ex_br_taken = 1'b0; ex_br_target = '0;
    step(); step();
    chk("rst_addr",   imem_addr, 32'h0);
    chk("rst_valid",  {31'd0, if_id_valid}, 32'd0);
    chk("rst_inst",   if_id_inst, 32'h00000013);
    chk("rst_pc",     if_id_pc, 32'h0);
    chk("rst_ptaken", {31'd0, if_id_pred_taken}, 32'd0);
    chk("rst_ptgt",   if_id_pred_target, 32'h0);
    rst = 1'b0;

    // straight-line fetch
    step();
    chk("sl1_addr",  imem_addr, 32'h4);
    chk("sl1_valid", {31'd0, if_id_valid}, 32'd1);
    chk("sl1_pc",    if_id_pc, 32'h0);
    chk("sl1_opc",   {25'd0, if_id_opcode}, 32'h33);
    chk("sl1_rs1",   {27'd0, if_id_rs1}, 32'd1);
    chk("sl1_rs2",   {27'd0, if_id_rs2}, 32'd2);
    step();
    chk("sl2_addr",  imem_addr, 32'h8);
    chk("sl2_pc",    if_id_pc, 32'h4);
    chk("sl2_rs1",   {27'd0, if_id_rs1}, 32'd5);
    chk("sl2_rs2",   {27'd0, if_id_rs2}, 32'd7);
    chk("sl2_ptgt",  if_id_pred_target, 32'h8);
    step();
    chk("sl3_rs2",   {27'd0, if_id_rs2}, 32'd31);
    step();
    chk("sl4_addr",  imem_addr, 32'h10);
    chk("sl4_pc",    if_id_pc, 32'hC);

    // load-use stall for two cycles at pc=0x10
    pc_write = 1'b0; if_id_write = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_addr", imem_addr, 32'h10);
      chk("stall_idpc", if_id_pc, 32'hC);
      chk("stall_inst", if_id_inst, imem[3]);
    end
    pc_write = 1'b1; if_id_write = 1'b1;
    step();
    chk("rel_addr", imem_addr, 32'h14);
    chk("rel_idpc", if_id_pc, 32'h10);

    // JAL at 0x20
    step(); step(); step();
    chk("pre_jal_addr", imem_addr, 32'h20);
    step();
    chk("jal_addr",   imem_addr, 32'h60);
    chk("jal_idpc",   if_id_pc, 32'h20);
    chk("jal_ptaken", {31'd0, if_id_pred_taken}, 32'd1);
    chk("jal_ptgt",   if_id_pred_target, 32'h60);

    // BHT training on the branch at 0x30
    redirect_to(32'h30);
    chk("redir_addr",  imem_addr, 32'h30);
    chk("redir_valid", {31'd0, if_id_valid}, 32'd0);
    step();
    chk("cold_addr",   imem_addr, 32'h34);
    chk("cold_ptaken", {31'd0, if_id_pred_taken}, 32'd0);
    chk("cold_ptgt",   if_id_pred_target, 32'h34);
    br_update(1'b1, 3);
    redirect_to(32'h30); step();
    chk("trained_addr",   imem_addr, 32'h80);
    chk("trained_ptaken", {31'd0, if_id_pred_taken}, 32'd1);
    chk("trained_ptgt",   if_id_pred_target, 32'h80);
    br_update(1'b0, 1);
    redirect_to(32'h30); step();
    chk("nt1_addr", imem_addr, 32'h80);
    br_update(1'b0, 1);
    redirect_to(32'h30); step();
    chk("nt2_addr",   imem_addr, 32'h34);
    chk("nt2_ptaken", {31'd0, if_id_pred_taken}, 32'd0);

    // redirect beats a simultaneous stall
    step();
    chk("pre5_valid", {31'd0, if_id_valid}, 32'd1);
    pc_write = 1'b0; if_id_write = 1'b0;
    redirect_to(32'h100);
    chk("rs_addr",  imem_addr, 32'h100);
    chk("rs_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rs_inst",  if_id_inst, 32'h00000013);
    chk("rs_opc",   {25'd0, if_id_opcode}, 32'h13);
    pc_write = 1'b1; if_id_write = 1'b1;

    // mid-stream reset while a branch update is in flight
    br_update(1'b1, 1);
    redirect_to(32'h30); step();
    chk("pre6_addr", imem_addr, 32'h80);
    rst = 1'b1;
    ex_br_valid = 1'b1; ex_br_pc = 32'h30; ex_br_taken = 1'b1; ex_br_target = 32'h80;
    step();
    rst = 1'b0; ex_br_valid = 1'b0;
    chk("mrst_addr",   imem_addr, 32'h0);
    chk("mrst_valid",  {31'd0, if_id_valid}, 32'd0);
    chk("mrst_inst",   if_id_inst, 32'h00000013);
    chk("mrst_ptaken", {31'd0, if_id_pred_taken}, 32'd0);
    redirect_to(32'h30); step();
    chk("post_addr",   imem_addr, 32'h34);
    chk("post_ptaken", {31'd0, if_id_pred_taken}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
